detector_botoes_debounce: RTL and testbench
===========================================

# detector_botoes_debounce

Parametrised multi-channel push-button front end: synchronises N active-low board buttons, debounces each channel independently with a cycle counter, and emits one-cycle press and release flags plus a clean level per channel. Optional auto-repeat pulses while a button is held. Sits directly between the board button pins and the control FSMs, replacing per-button single-channel edge detectors.

## Interface
- `N_BOTOES`, 4: number of button channels (≥1).
- `DEBOUNCE_CICLOS`, 250000: consecutive stable cycles required to accept a change (5 ms at 50 MHz); minimum 2.
- `HOLD_CICLOS`, 25000000: held cycles from accepted press to first repeat pulse (used only with `DETECTOR_REPEAT_EN`).
- `REPEAT_CICLOS`, 5000000: cycles between subsequent repeat pulses (used only with `DETECTOR_REPEAT_EN`).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `botoes_n`  in  N_BOTOES  raw button pins, asynchronous; 0 = pressed, 1 = released.
- `estado`  out  N_BOTOES  debounced level, 1 = pressed.
- `flag_press`  out  N_BOTOES  one-cycle pulse on accepted press.
- `flag_solta`  out  N_BOTOES  one-cycle pulse on accepted release.
- `flag_repete`  out  N_BOTOES  one-cycle auto-repeat pulse; constant 0 without `DETECTOR_REPEAT_EN`.

## Operation
- Per channel: 2-flop synchroniser → debounce counter → stable-state register → flag generation. Channels fully independent; simultaneous events on different channels all reported in the same cycle.
- Synchroniser flops reset to 1 (released); `estado` resets to 0.
- Mismatch = synchronised level (inverted to active-high) ≠ `estado`. Each mismatch cycle increments the counter; any match cycle clears it to 0.
- When counter = DEBOUNCE_CICLOS−1 and mismatch persists: `estado` toggles, counter clears, and `flag_press` (0→1) or `flag_solta` (1→0) asserts for exactly one cycle.
- Bounces shorter than DEBOUNCE_CICLOS cycles produce no flag and no `estado` change.
- Counter width `$clog2(DEBOUNCE_CICLOS)`; never wraps (cleared on acceptance or match).
- Reset asserted mid-operation: all flops to reset values immediately; no flags during or at exit of reset. A button held through reset deassertion is reported as a fresh press after the normal debounce latency.
- Reset values: `estado`=0, `flag_press`=0, `flag_solta`=0, `flag_repete`=0, all counters 0.

## Timing
- Pin change sampled first at edge E0 (stable afterwards): `estado` and the flag update at edge E0+1+DEBOUNCE_CICLOS; flag high for that single cycle.
- `flag_press` and `flag_solta` never both high on one channel in one cycle.
- Repeat: first `flag_repete` at edge HOLD_CICLOS after the edge that set `estado`; then every REPEAT_CICLOS edges while `estado`=1. Accepted release clears the repeat counter the same edge; no repeat pulse coincides with `flag_solta`.

## Configuration
- `DETECTOR_REPEAT_EN` defined: per-channel repeat counter (width `$clog2(max(HOLD_CICLOS,REPEAT_CICLOS))`) and phase bit (waiting-hold / repeating) built; `flag_repete` driven as above.
- Not defined: repeat logic absent, `flag_repete` tied to 0, HOLD/REPEAT parameters ignored.

## Structure
- Shared package `detector_pkg`: default cycle constants for 50 MHz (5 ms debounce, 500 ms hold, 100 ms repeat), button-level constants `BOTAO_PRESSIONADO`=0 / `BOTAO_SOLTO`=1.
- One sub-module `debounce_canal` (single channel: sync, counter, state, flags, optional repeat); top instantiates N_BOTOES copies with a generate loop.

## Test plan
Bench parameters: N_BOTOES=4, DEBOUNCE_CICLOS=4, HOLD_CICLOS=10, REPEAT_CICLOS=3.
- Clean press on ch0 first sampled at E0 → `estado[0]`=1 and `flag_press[0]`=1 at E0+5 only; other channels stay 0.
- Ch1 bounce: low 3 cycles, high 1, low held → single `flag_press[1]` 5 edges after last falling transition; no flag for the 3-cycle glitch.
- Release of ch0 after stable press → one `flag_solta[0]` pulse 5 edges after first sampled high; `estado[0]` returns 0.
- Ch2 and ch3 pressed same cycle → both `flag_press` bits high in the same cycle.
- Repeat (macro on): ch0 held → `flag_repete[0]` at 10 edges after press, then every 3; release stops pulses, none coincides with `flag_solta`. Macro off → `flag_repete`=0 throughout.
- `rst_n` pulsed low while ch0 held mid-debounce → all outputs 0 immediately; after release of reset, `flag_press[0]` again after 5 edges.

Source files
------------

// File: rtl/detector_pkg.sv
// Shared constants for the push-button front end: 50 MHz default timings and raw pin levels.
package detector_pkg;

    localparam int DEBOUNCE_PADRAO = 250_000;     // 5 ms
    localparam int HOLD_PADRAO     = 25_000_000;  // 500 ms
    localparam int REPEAT_PADRAO   = 5_000_000;   // 100 ms

    localparam logic BOTAO_PRESSIONADO = 1'b0;
    localparam logic BOTAO_SOLTO       = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_canal.sv
// Single button channel: 2-flop synchroniser, stability counter, debounced level and edge flags.
// Auto-repeat pulses are built only when DETECTOR_REPEAT_EN is defined.
module debounce_canal
    import detector_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
    parameter int HOLD_CICLOS     = HOLD_PADRAO,
    parameter int REPEAT_CICLOS   = REPEAT_PADRAO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botao_n,
    output logic estado,
    output logic flag_press,
    output logic flag_solta,
    output logic flag_repete
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

    if (DEBOUNCE_CICLOS < 2) begin : g_erro_debounce
        $error("DEBOUNCE_CICLOS must be at least 2");
    end
    if (HOLD_CICLOS < 1 || REPEAT_CICLOS < 1) begin : g_erro_repeat
        $error("HOLD_CICLOS and REPEAT_CICLOS must be at least 1");
    end

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          estado_q, estado_d;
    logic          press_q, press_d, solta_q, solta_d;
    logic          nivel, aceita;

    always_comb begin
        sync1_d  = botao_n;
        sync2_d  = sync1_q;
        nivel    = (sync2_q == BOTAO_PRESSIONADO);
        aceita   = (nivel != estado_q) && (cnt_q == CNT_FIM);
        // any cycle where the synchronised level agrees with estado restarts the window
        cnt_d    = '0;
        if ((nivel != estado_q) && !aceita)
            cnt_d = cnt_q + 1'b1;
        estado_d = estado_q ^ aceita;
        press_d  = aceita & ~estado_q;
        solta_d  = aceita & estado_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= BOTAO_SOLTO;
            sync2_q  <= BOTAO_SOLTO;
            cnt_q    <= '0;
            estado_q <= 1'b0;
            press_q  <= 1'b0;
            solta_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            estado_q <= estado_d;
            press_q  <= press_d;
            solta_q  <= solta_d;
        end
    end

    assign estado     = estado_q;
    assign flag_press = press_q;
    assign flag_solta = solta_q;

`ifdef DETECTOR_REPEAT_EN
    localparam int RW = $clog2(max_int(max_int(HOLD_CICLOS, REPEAT_CICLOS), 2));
    localparam logic [RW-1:0] HOLD_FIM = RW'(HOLD_CICLOS - 1);
    localparam logic [RW-1:0] REP_FIM  = RW'(REPEAT_CICLOS - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          fase_q, fase_d;      // 0: waiting for hold, 1: repeating
    logic          repete_q, repete_d;

    always_comb begin
        rep_cnt_d = '0;
        fase_d    = 1'b0;
        repete_d  = 1'b0;
        // counting only while held; the release-accept edge clears so no pulse lands with flag_solta
        if (estado_q && !aceita) begin
            if (rep_cnt_q == (fase_q ? REP_FIM : HOLD_FIM)) begin
                repete_d = 1'b1;
                fase_d   = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
                fase_d    = fase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q <= '0;
            fase_q    <= 1'b0;
            repete_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            fase_q    <= fase_d;
            repete_q  <= repete_d;
        end
    end

    assign flag_repete = repete_q;
`else
    assign flag_repete = 1'b0;
`endif

endmodule

// File: rtl/detector_botoes_debounce.sv
// N-channel active-low push-button front end; one independent debounce_canal per button.
// Auto-repeat is enabled by defining DETECTOR_REPEAT_EN.
module detector_botoes_debounce
    import detector_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
    parameter int HOLD_CICLOS     = HOLD_PADRAO,
    parameter int REPEAT_CICLOS   = REPEAT_PADRAO
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_BOTOES-1:0] botoes_n,
    output logic [N_BOTOES-1:0] estado,
    output logic [N_BOTOES-1:0] flag_press,
    output logic [N_BOTOES-1:0] flag_solta,
    output logic [N_BOTOES-1:0] flag_repete
);

    for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
        debounce_canal #(
            .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
            .HOLD_CICLOS     (HOLD_CICLOS),
            .REPEAT_CICLOS   (REPEAT_CICLOS)
        ) u_canal (
            .clk         (clk),
            .rst_n       (rst_n),
            .botao_n     (botoes_n[i]),
            .estado      (estado[i]),
            .flag_press  (flag_press[i]),
            .flag_solta  (flag_solta[i]),
            .flag_repete (flag_repete[i])
        );
    end

endmodule

// File: tb/tb_detector_botoes_debounce.sv
// Scoreboard bench for detector_botoes_debounce: expected flag events are queued per clock edge
// when a button is driven and compared every cycle; estado is tracked from the queued events.
module tb_detector_botoes_debounce;

    localparam int N    = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;
    localparam int LAT  = DEB + 2;  // drive at negedge k -> output visible at negedge k+LAT

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] botoes_n = '1;
    logic [N-1:0] estado, flag_press, flag_solta, flag_repete;

    typedef struct {
        int           ciclo;
        logic [N-1:0] press;
        logic [N-1:0] solta;
        logic [N-1:0] repete;
    } evento_t;

    evento_t      fila[$];
    evento_t      ev_mon;
    int           n_borda = 0;
    int           n_verif = 0;
    int           n_falhas = 0;
    logic [N-1:0] est_exp = '0;
    bit           monitor_on = 1'b0;

    detector_botoes_debounce #(
        .N_BOTOES        (N),
        .DEBOUNCE_CICLOS (DEB),
        .HOLD_CICLOS     (HOLD),
        .REPEAT_CICLOS   (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .botoes_n    (botoes_n),
        .estado      (estado),
        .flag_press  (flag_press),
        .flag_solta  (flag_solta),
        .flag_repete (flag_repete)
    );

    always #5 clk = ~clk;
    always @(posedge clk) n_borda <= n_borda + 1;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_verif++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, esp, n_borda);
        end
    endtask

    task automatic empurra(input int c, input logic [N-1:0] p, input logic [N-1:0] s,
                           input logic [N-1:0] r);
        evento_t e;
        int i;
        i = 0;
        while (i < fila.size() && fila[i].ciclo < c) i++;
        if (i < fila.size() && fila[i].ciclo == c) begin
            e = fila[i];
            e.press  = e.press | p;
            e.solta  = e.solta | s;
            e.repete = e.repete | r;
            fila[i]  = e;
        end else begin
            e.ciclo  = c;
            e.press  = p;
            e.solta  = s;
            e.repete = r;
            fila.insert(i, e);
        end
    endtask

    // Press driven at negedge t, released at negedge t+baixo.
    task automatic planeja(input logic [N-1:0] mask, input int t, input int baixo);
        int p, r;
        p = t + LAT;
        r = t + baixo + LAT;
        empurra(p, mask, '0, '0);
`ifdef DETECTOR_REPEAT_EN
        for (int c = p + HOLD; c < r; c += REP) empurra(c, '0, '0, mask);
`endif
        empurra(r, '0, mask, '0);
    endtask

    task automatic aguarda_fila();
        for (int i = 0; i < 100 && fila.size() > 0; i++) @(negedge clk);
        verifica("fila_vazia", 32'(fila.size()), 32'd0);
    endtask

    task automatic botao_pulso(input logic [N-1:0] mask, input int baixo);
        planeja(mask, n_borda, baixo);
        botoes_n = botoes_n & ~mask;
        repeat (baixo) @(negedge clk);
        botoes_n = botoes_n | mask;
        aguarda_fila();
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            est_exp = '0;
        end else if (monitor_on) begin
            while (fila.size() > 0 && fila[0].ciclo < n_borda) begin
                verifica("evento_perdido", 32'(fila[0].ciclo), 32'(n_borda));
                void'(fila.pop_front());
            end
            if (fila.size() > 0 && fila[0].ciclo == n_borda) begin
                ev_mon = fila.pop_front();
                verifica("flag_press", 32'(flag_press), 32'(ev_mon.press));
                verifica("flag_solta", 32'(flag_solta), 32'(ev_mon.solta));
                verifica("flag_repete", 32'(flag_repete), 32'(ev_mon.repete));
                est_exp = (est_exp | ev_mon.press) & ~ev_mon.solta;
            end else begin
                verifica("flags_ociosas", 32'({flag_press, flag_solta, flag_repete}), 32'd0);
            end
            verifica("estado", 32'(estado), 32'(est_exp));
        end
    end

    initial begin
        int t;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        verifica("rst_estado", 32'(estado), 32'd0);
        verifica("rst_press", 32'(flag_press), 32'd0);
        verifica("rst_solta", 32'(flag_solta), 32'd0);
        verifica("rst_repete", 32'(flag_repete), 32'd0);
        rst_n = 1'b1;
        monitor_on = 1'b1;
        repeat (3) @(negedge clk);

        // clean press/release on ch0, long enough to see repeats when enabled
        botao_pulso(4'b0001, 20);

        // ch1: 3-cycle glitch then held low
        botoes_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        botoes_n[1] = 1'b1;
        @(negedge clk);
        botao_pulso(4'b0010, 8);

        // ch2 and ch3 together
        botao_pulso(4'b1100, 6);

        // shortest accepted pulse: exactly DEB cycles
        botao_pulso(4'b1000, DEB);

        // reset while ch1 is pressed and ch0 is mid-debounce
        t = n_borda;
        botoes_n[1] = 1'b0;
        empurra(t + LAT, 4'b0010, '0, '0);
        repeat (LAT + 2) @(negedge clk);
        botoes_n[0] = 1'b0;
        repeat (2) @(negedge clk);
        monitor_on = 1'b0;
        @(negedge clk);
        verifica("pre_reset_estado", 32'(estado), 32'h2);
        rst_n = 1'b0;
        #1;
        verifica("rst_async_estado", 32'(estado), 32'd0);
        verifica("rst_async_flags", 32'({flag_press, flag_solta, flag_repete}), 32'd0);
        botoes_n[1] = 1'b1;
        repeat (2) @(negedge clk);
        verifica("rst_mantido", 32'({estado, flag_press, flag_solta, flag_repete}), 32'd0);
        rst_n = 1'b1;
        monitor_on = 1'b1;
        planeja(4'b0001, n_borda, 12);
        repeat (12) @(negedge clk);
        botoes_n[0] = 1'b1;
        aguarda_fila();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_falhas);
        $fatal(1, "watchdog");
    end

endmodule
